// File: rtl/c880_seq_pkg.sv
// c880_seq_pkg
// Shared constants and types for the c880 byte-serial vector sequencer.
//   VEC_W / RES_W   : c880 input / output vector widths
//   BEAT_W / BEATS  : beat payload width and beats per frame
//   ASM_W           : bits held in the assembly register (beats 0..6)
//   state_e         : sequencer FSM states
//   N*_BIT          : bit positions of the end-of-range c880 pins
package c880_seq_pkg;

    localparam int VEC_W  = 60;
    localparam int RES_W  = 26;
    localparam int BEAT_W = 8;
    localparam int BEATS  = 8;
    localparam int BCNT_W = $clog2(BEATS);

    // Beat 7 goes straight into core_in, so only beats 0..6 need storage.
    localparam int ASM_W  = (BEATS - 1) * BEAT_W;

    // Pin mapping: bit i of core_in is the i-th c880 input in port order,
    // bit j of core_out is the j-th c880 output in port order.
    localparam int N1_BIT   = 0;
    localparam int N268_BIT = VEC_W - 1;
    localparam int N388_BIT = 0;
    localparam int N880_BIT = RES_W - 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/c880_vector_sequencer_if.sv
// c880_vector_sequencer_if
// Beat input stream and result output stream of the c880 sequencer.
//   in_valid/in_ready/in_data/in_last : beat stream into the sequencer
//   res_valid/res_ready/res_data      : captured c880 response out
// master = stimulus producer / result consumer, slave = the sequencer.
interface c880_vector_sequencer_if;
    import c880_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_last;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/c880_vector_sequencer.sv
// c880_vector_sequencer
// Assembles a 60-bit c880 input vector from eight little-endian byte beats,
// holds it on core_in, waits SETTLE_CYCLES extra cycles, then captures the
// c880 outputs and offers them on the result handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : beat input stream + result output stream (slave side)
//   core_in    : registered vector driven to the c880 core
//   core_out   : c880 core outputs, sampled at capture
//   frame_err  : one-cycle pulse after a misplaced / missing in_last
//   busy       : high while in SETTLE or HOLD
module c880_vector_sequencer
    import c880_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    c880_vector_sequencer_if.slave  bus,
    output logic [VEC_W-1:0]        core_in,
    input  logic [RES_W-1:0]        core_out,
    output logic                    frame_err,
    output logic                    busy
);

    if ((1 << CNT_W) <= SETTLE_CYCLES) begin : g_cnt_chk
        $error("CNT_W too narrow for SETTLE_CYCLES");
    end

    state_e             state_q, state_d;
    logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic [VEC_W-1:0]   core_in_q, core_in_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic               res_valid_q, res_valid_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic               frame_err_q, frame_err_d;
    logic               last_beat;

    assign last_beat = (beat_cnt_q == BCNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            core_in_q   <= '0;
            settle_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            core_in_q   <= core_in_d;
            settle_q    <= settle_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        asm_d       = asm_q;
        core_in_d   = core_in_q;
        settle_d    = settle_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone accepts.
                if (bus.in_valid) begin
                    if (bus.in_last != last_beat) begin
                        // Beat is swallowed; the partial frame is abandoned.
                        frame_err_d = 1'b1;
                        beat_cnt_d  = '0;
                    end else if (last_beat) begin
                        // Only the low nibble of beat 7 reaches the core.
                        core_in_d  = {bus.in_data[VEC_W-ASM_W-1:0], asm_q};
                        settle_d   = CNT_W'(SETTLE_CYCLES);
                        beat_cnt_d = '0;
                        state_d    = ST_SETTLE;
                    end else begin
                        for (int k = 0; k < BEATS - 1; k++) begin
                            if (beat_cnt_q == BCNT_W'(k)) begin
                                asm_d[k*BEAT_W +: BEAT_W] = bus.in_data;
                            end
                        end
                        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - CNT_W'(1);
                end else begin
                    res_data_d  = core_out;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // in_ready and busy depend on state only: no input-to-output path.
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign busy          = (state_q != ST_LOAD);
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign core_in       = core_in_q;
    assign frame_err     = frame_err_q;

endmodule
